reductor_saturado: RTL and testbench

Inverse of the fixed-point width extender. Takes a 2N-bit wide product/accumulator value and reduces it back to the N-bit datapath format: drops the FB padding LSBs with optional rounding, then saturates integer overflow.
- Wide format: sign-extended, FA+FB fractional bits.
- Narrow format: 1 sign bit, MB integer bits, FA fractional bits.
- Sits between the multiply/accumulate stage and the N-bit register file/output path.
- Two-stage valid/ready pipeline with a saturation event counter.

---
 rtl/formato_pkg.sv | 42 ++++
 rtl/etapa_handshake.sv | 53 +++++
 rtl/reductor_saturado.sv | 90 +++++++++
 tb/tb_reductor_saturado.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/formato_pkg.sv
// Fixed-point format constants shared by the width extender and the saturating reducer.
// Narrow word: sign + MB integer + FA fraction. Wide word: 2N bits, FA+FB fraction.
package formato_pkg;

   localparam int N  = 25;
   localparam int MB = 10;
   localparam int FA = 14;
   localparam int FB = 19;
   localparam int MA = 2 * N - 1 - FA - FB;
   localparam int WW = 2 * N;
   localparam int RW = 2 * N + 1 - FB;
   localparam int CW = 16;

   localparam logic [N-1:0]  SAT_MAX    = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]  SAT_MIN    = {1'b1, {(N-1){1'b0}}};
   localparam logic [WW:0]   ROUND_HALF = {{(WW-FB+1){1'b0}}, 1'b1, {(FB-1){1'b0}}};
   localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

   typedef struct packed {
      logic         sat;
      logic [N-1:0] data;
   } narrow_t;

   // The value fits the narrow word only when every bit above the narrow sign bit repeats it.
   function automatic narrow_t satura(input logic [RW-1:0] r);
      narrow_t res;
      logic    fits;
      fits = (&r[RW-1:N-1]) || !(|r[RW-1:N-1]);
      if (fits) begin
         res.sat  = 1'b0;
         res.data = r[N-1:0];
      end else if (!r[RW-1]) begin
         res.sat  = 1'b1;
         res.data = SAT_MAX;
      end else begin
         res.sat  = 1'b1;
         res.data = SAT_MIN;
      end
      return res;
   endfunction

endpackage

// File: rtl/etapa_handshake.sv
// One valid/ready pipeline register; loads when empty or when its content leaves this cycle.
module etapa_handshake #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic         valid_d;
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;
   logic         load;

   // Payload only changes on an accepted sample, so it holds steady while stalled.
   always_comb begin
      load    = !valid_q || ready_i;
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = data_i;
         end else begin
            data_d = data_q;
         end
      end else begin
         valid_d = valid_q;
         data_d  = data_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= {W{1'b0}};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign ready_o = load;
   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/reductor_saturado.sv
// Reduces a 2N-bit fixed-point value to N bits: drop FB LSBs (rounded when REDONDEO_EN
// is defined, floor otherwise), then clamp integer overflow; counts clamped outputs.
module reductor_saturado
   import formato_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data,
   output logic          out_sat,
   input  logic          clr_count,
   output logic [CW-1:0] sat_count
);

   logic [WW:0]   ext_s;
   logic [WW:0]   sum_s;
   logic [RW-1:0] r_in_s;
   logic [RW-1:0] r_q;
   logic          s1_valid;
   logic          s2_ready;
   narrow_t       n_in_s;
   narrow_t       n_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The extra top bit keeps the rounding carry from wrapping at the positive maximum.
   always_comb begin
      ext_s = {in_data[WW-1], in_data};
`ifdef REDONDEO_EN
      sum_s = ext_s + ROUND_HALF;
`else
      sum_s = ext_s;
`endif
      r_in_s = RW'(sum_s >> FB);
   end

   etapa_handshake #(.W(RW)) u_etapa_redondeo (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (in_valid),
      .ready_o (in_ready),
      .data_i  (r_in_s),
      .valid_o (s1_valid),
      .ready_i (s2_ready),
      .data_o  (r_q)
   );

   assign n_in_s = satura(r_q);

   etapa_handshake #(.W(N + 1)) u_etapa_satura (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (s1_valid),
      .ready_o (s2_ready),
      .data_i  (n_in_s),
      .valid_o (out_valid),
      .ready_i (out_ready),
      .data_o  (n_q)
   );

   assign out_data = n_q.data;
   assign out_sat  = n_q.sat;

   // Clear has priority over a clamped transfer; the count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_count) begin
         cnt_d = {CW{1'b0}};
      end else if (out_valid && out_ready && out_sat && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_count = cnt_q;

endmodule

// File: tb/tb_reductor_saturado.sv
// Directed bench for reductor_saturado with an arithmetic reference model and scoreboard.
module tb_reductor_saturado;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [49:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] out_data;
   logic        out_sat;
   logic        clr_count;
   logic [15:0] sat_count;

   reductor_saturado dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .clr_count (clr_count),
      .sat_count (sat_count)
   );

   typedef struct {
      logic [49:0] d;
      logic        hand;
      logic [24:0] hq;
      logic        hs;
   } ent_t;

   ent_t        sb[$];
   int          vectors = 0;
   int          errors  = 0;
   int          cnt_m   = 0;
   logic        cur_hand;
   logic [24:0] cur_hq;
   logic        cur_hs;
   logic        prev_stall = 1'b0;
   logic [24:0] prev_d;
   logic        prev_s;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: scale by 2^-19 with floor (after +2^18 when rounding), then clamp to 25 bits.
   function automatic void model(input logic [49:0] d, output logic [24:0] q, output logic s);
      longint v;
      longint r;
      v = longint'($signed(d));
`ifdef REDONDEO_EN
      v = v + 64'sd262144;
`endif
      r = v >>> 19;
      if (r > 64'sd16777215) begin
         q = 25'h0FFFFFF;
         s = 1'b1;
      end else if (r < -64'sd16777216) begin
         q = 25'h1000000;
         s = 1'b1;
      end else begin
         q = r[24:0];
         s = 1'b0;
      end
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: checks every output transfer, the counter, and stall stability.
   always @(negedge clk) begin
      ent_t        e;
      logic [24:0] mq;
      logic        ms;
      logic        xsat;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         xsat = 1'b0;
         vectors++;
         if (sat_count !== cnt_m[15:0]) begin
            errors++;
            $display("FAIL sat_count: got %0d expected %0d", sat_count, cnt_m);
         end
         if (prev_stall) begin
            vectors++;
            if (!out_valid || out_data !== prev_d || out_sat !== prev_s) begin
               errors++;
               $display("FAIL hold: got v=%0b d=%0h s=%0b expected v=1 d=%0h s=%0b",
                        out_valid, out_data, out_sat, prev_d, prev_s);
            end
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               errors++;
               vectors++;
               $display("FAIL unexpected_out: got d=%0h expected no output", out_data);
            end else begin
               e = sb.pop_front();
               model(e.d, mq, ms);
               xsat = ms;
               vectors++;
               if (out_data !== mq || out_sat !== ms) begin
                  errors++;
                  $display("FAIL model in=%0h: got d=%0h s=%0b expected d=%0h s=%0b",
                           e.d, out_data, out_sat, mq, ms);
               end
               if (e.hand) begin
                  vectors++;
                  if (out_data !== e.hq || out_sat !== e.hs) begin
                     errors++;
                     $display("FAIL hand in=%0h: got d=%0h s=%0b expected d=%0h s=%0b",
                              e.d, out_data, out_sat, e.hq, e.hs);
                  end
               end
            end
         end
         if (clr_count) cnt_m = 0;
         else if (xsat && cnt_m < 65535) cnt_m = cnt_m + 1;
         if (in_valid && in_ready) sb.push_back('{in_data, cur_hand, cur_hq, cur_hs});
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         prev_s     = out_sat;
      end
   end

   task automatic send(input logic [49:0] d, input logic hand, input logic [24:0] hq, input logic hs);
      logic acc;
      in_data  = d;
      cur_hand = hand;
      cur_hq   = hq;
      cur_hs   = hs;
      in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      errors++;
      vectors++;
      $display("FAIL send_timeout: got no in_ready expected acceptance of %0h", d);
   endtask

   task automatic drain();
      for (int t = 0; t < 200; t++) begin
         if (sb.size() == 0 && !out_valid) return;
         @(posedge clk);
         #1;
      end
      errors++;
      vectors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 50'h0;
      out_ready = 1'b1;
      clr_count = 1'b0;
      cur_hand  = 1'b0;
      cur_hq    = 25'h0;
      cur_hs    = 1'b0;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data",  64'(out_data),  64'h0);
      chk("rst_out_sat",   64'(out_sat),   64'h0);
      chk("rst_sat_count", 64'(sat_count), 64'h0);
      chk("rst_in_ready",  64'(in_ready),  64'h1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Nominal +1.0 with explicit two-cycle latency.
      in_data  = 50'h0_0002_0000_0000;
      cur_hand = 1'b1;
      cur_hq   = 25'h0004000;
      cur_hs   = 1'b0;
      in_valid = 1'b1;
      chk("lat_in_ready", 64'(in_ready), 64'h1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("lat_cycle1_valid", 64'(out_valid), 64'h0);
      @(posedge clk);
      #1;
      chk("lat_cycle2_valid", 64'(out_valid), 64'h1);
      chk("lat_cycle2_data",  64'(out_data),  64'h0004000);
      chk("lat_cycle2_sat",   64'(out_sat),   64'h0);
      drain();

      send(50'h3_FFFE_0000_0000, 1'b1, 25'h1FFC000, 1'b0);
`ifdef REDONDEO_EN
      send(50'h0_0002_0004_0000, 1'b1, 25'h0004001, 1'b0);
      send(50'h3_FFFD_FFFC_0000, 1'b1, 25'h1FFC000, 1'b0);
`else
      send(50'h0_0002_0004_0000, 1'b1, 25'h0004000, 1'b0);
      send(50'h3_FFFD_FFFC_0000, 1'b1, 25'h1FFBFFF, 1'b0);
`endif
      send(50'h0, 1'b1, 25'h0000000, 1'b0);
      send(50'h0_07FF_FFF8_0000, 1'b1, 25'h0FFFFFF, 1'b0);
      send(50'h3_F800_0000_0000, 1'b1, 25'h1000000, 1'b0);
      drain();
      chk("count_after_nominal", 64'(sat_count), 64'h0);

      send(50'h0_0800_0000_0000, 1'b1, 25'h0FFFFFF, 1'b1);
      drain();
      chk("count_after_pos_sat", 64'(sat_count), 64'h1);
      send(50'h2_0000_0000_0000, 1'b1, 25'h1000000, 1'b1);
      drain();
      chk("count_after_neg_sat", 64'(sat_count), 64'h2);
`ifdef REDONDEO_EN
      send(50'h0_07FF_FFFC_0000, 1'b1, 25'h0FFFFFF, 1'b1);
`else
      send(50'h0_07FF_FFFC_0000, 1'b1, 25'h0FFFFFF, 1'b0);
`endif
      drain();

      // Backpressure: five back-to-back samples against a 4-cycle stall.
      out_ready = 1'b0;
      fork
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            send(50'h0_0004_0000_0000, 1'b1, 25'h0008000, 1'b0);
            send(50'h0_0006_0000_0000, 1'b1, 25'h000C000, 1'b0);
            chk("bp_in_ready_low", 64'(in_ready), 64'h0);
            send(50'h3_FFFC_0000_0000, 1'b1, 25'h1FF8000, 1'b0);
            send(50'h0_0000_8000_0000, 1'b1, 25'h0001000, 1'b0);
            send(50'h0_00C8_0000_0000, 1'b1, 25'h0190000, 1'b0);
         end
      join
      drain();

      // Clear coincident with a clamped transfer.
      out_ready = 1'b0;
      send(50'h0_0800_0000_0000, 1'b1, 25'h0FFFFFF, 1'b1);
      for (int t = 0; t < 20 && !out_valid; t++) begin
         @(posedge clk);
         #1;
      end
      chk("clr_wait_valid", 64'(out_valid), 64'h1);
      clr_count = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 clr_count = 1'b0;
      chk("clr_wins", 64'(sat_count), 64'h0);
      drain();

      // Reset with two samples in flight.
      out_ready = 1'b0;
      send(50'h0_0002_0000_0000, 1'b0, 25'h0, 1'b0);
      send(50'h0_0800_0000_0000, 1'b0, 25'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'h0);
      chk("midrst_in_ready",  64'(in_ready),  64'h1);
      sb.delete();
      cnt_m = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_no_stale", 64'(out_valid), 64'h0);
      send(50'h3_FFFE_0000_0000, 1'b1, 25'h1FFC000, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
